// File: rtl/stopwatch_display_scan.sv
// Frame-coherent scanner driving seven BCD stopwatch digits onto a multiplexed common-anode
// 7-segment display. Defining DISP_BLINK_EN blinks whole frames while the stopwatch is stopped.
module stopwatch_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_LOG2   = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       STOPWATCH_RUN,
    input  logic [3:0] HOUR,
    input  logic [2:0] MINHIGH,
    input  logic [3:0] MINLOW,
    input  logic [2:0] SECHIGH,
    input  logic [3:0] SECLOW,
    input  logic [3:0] MSEC1ST,
    input  logic [3:0] MSEC2ND,
    output logic [6:0] DIGIT_SEL,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       FRAME_START
);

    localparam int            PW   = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0]   prescaler_q, prescaler_d;
    logic [2:0]      index_q, index_d;
    logic [6:0][3:0] shadow_q, shadow_d;
    logic [6:0][3:0] digit_in;
    logic [6:0]      digit_sel_q, digit_sel_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_start_q, frame_start_d;
    logic            last_slot, frame_end, blank, dark;
    logic [3:0]      digit_cur;

    // Scan order: digit 0 is the rightmost (hundredths), digit 6 the hours.
    assign digit_in[0] = MSEC2ND;
    assign digit_in[1] = MSEC1ST;
    assign digit_in[2] = SECLOW;
    assign digit_in[3] = {1'b0, SECHIGH};
    assign digit_in[4] = MINLOW;
    assign digit_in[5] = {1'b0, MINHIGH};
    assign digit_in[6] = HOUR;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

`ifdef DISP_BLINK_EN
    localparam int CW = (BLINK_LOG2 > 5) ? BLINK_LOG2 : 5;
    logic [CW-1:0] blink_cnt_q, blink_cnt_d;

    // Counts stopped frames; advancing on the snapshot edge keeps a whole frame uniform.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        if (STOPWATCH_RUN)
            blink_cnt_d = '0;
        else if (frame_end)
            blink_cnt_d = blink_cnt_q + CW'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            blink_cnt_q <= '0;
        else
            blink_cnt_q <= blink_cnt_d;
    end

    assign dark = !STOPWATCH_RUN && blink_cnt_q[BLINK_LOG2-1];
`else
    logic [31:0] unused_blink;
    assign unused_blink = 32'(BLINK_LOG2) ^ {31'd0, STOPWATCH_RUN};
    assign dark         = 1'b0;
`endif

    always_comb begin
        last_slot     = (prescaler_q == LAST);
        frame_end     = last_slot && (index_q == 3'd6);
        prescaler_d   = last_slot ? '0 : prescaler_q + PW'(1);
        index_d       = index_q;
        if (last_slot)
            index_d = (index_q == 3'd6) ? 3'd0 : index_q + 3'd1;
        shadow_d      = frame_end ? digit_in : shadow_q;
        frame_start_d = frame_end;

        // Output stage: what the current slot cycle shows, presented one clock later.
        blank       = (32'(prescaler_q) < 32'(BLANK_CYCLES));
        digit_cur   = shadow_q[index_q];
        digit_sel_d = (blank || dark) ? 7'h7F : ~(7'd1 << index_q);
        seg_d       = blank ? 7'h7F : seg_decode(digit_cur);
        dp_d        = blank || !((index_q == 3'd2) || (index_q == 3'd4) || (index_q == 3'd6));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescaler_q   <= '0;
            index_q       <= '0;
            shadow_q      <= '0;
            digit_sel_q   <= 7'h7F;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            index_q       <= index_d;
            shadow_q      <= shadow_d;
            digit_sel_q   <= digit_sel_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign DIGIT_SEL   = digit_sel_q;
    assign SEG         = seg_q;
    assign DP          = dp_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Bench for stopwatch_display_scan: directed steps plus random inputs, checked every cycle
// against a slot/frame arithmetic model of the scanner.
module tb_stopwatch_display_scan;

    localparam int D  = 4;
    localparam int B  = 1;
    localparam int L  = 1;
    localparam int FR = 7 * D;

    logic       CLK = 1'b0;
    logic       RST;
    logic       STOPWATCH_RUN;
    logic [3:0] HOUR, MINLOW, SECLOW, MSEC1ST, MSEC2ND;
    logic [2:0] MINHIGH, SECHIGH;
    logic [6:0] DIGIT_SEL, SEG;
    logic       DP, FRAME_START;

    int compared   = 0;
    int mismatched = 0;
    int n          = 0;
    int run_frames = 0;
    logic [6:0][3:0] snap [2];
    logic [6:0] e_sel, e_seg;
    logic       e_dp, e_fs;

    stopwatch_display_scan #(.SCAN_DIV(D), .BLANK_CYCLES(B), .BLINK_LOG2(L)) dut (
        .CLK(CLK), .RST(RST), .STOPWATCH_RUN(STOPWATCH_RUN),
        .HOUR(HOUR), .MINHIGH(MINHIGH), .MINLOW(MINLOW), .SECHIGH(SECHIGH),
        .SECLOW(SECLOW), .MSEC1ST(MSEC1ST), .MSEC2ND(MSEC2ND),
        .DIGIT_SEL(DIGIT_SEL), .SEG(SEG), .DP(DP), .FRAME_START(FRAME_START)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [6:0][3:0] inputs_now();
        return {HOUR, {1'b0, MINHIGH}, MINLOW, {1'b0, SECHIGH}, SECLOW, MSEC1ST, MSEC2ND};
    endfunction

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    // One clock: predict what the slot cycle just finished should show, then check at negedge.
    task automatic tick();
        int s, p, idx, f;
        logic blink;
        @(posedge CLK);
        n++;
        s   = n - 1;
        p   = s % D;
        idx = (s / D) % 7;
        f   = s / FR;
`ifdef DISP_BLINK_EN
        blink = !STOPWATCH_RUN && (((run_frames >> (L - 1)) & 1) == 1);
`else
        blink = 1'b0;
`endif
        if (p < B) begin
            e_sel = 7'h7F;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            e_sel = blink ? 7'h7F : ~(7'd1 << idx);
            e_seg = seg_of(snap[f % 2][idx]);
            e_dp  = !((idx == 2) || (idx == 4) || (idx == 6));
        end
        e_fs = (n % FR == 0);
        if (n % FR == 0)
            snap[(n / FR) % 2] = inputs_now();
        if (STOPWATCH_RUN)
            run_frames = 0;
        else if (n % FR == 0)
            run_frames = (run_frames + 1) % 32;
        @(negedge CLK);
        chk("digit_sel", DIGIT_SEL, e_sel);
        chk("seg", SEG, e_seg);
        chk("dp", {6'd0, DP}, {6'd0, e_dp});
        chk("frame_start", {6'd0, FRAME_START}, {6'd0, e_fs});
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sel"}, DIGIT_SEL, 7'h7F);
        chk({tag, "_seg"}, SEG, 7'h7F);
        chk({tag, "_dp"}, {6'd0, DP}, 7'd1);
        chk({tag, "_fs"}, {6'd0, FRAME_START}, 7'd0);
    endtask

    // Called at a negedge; asserts reset, checks it bites before any clock, releases later.
    task automatic do_reset(input int hold);
        RST = 1'b0;
        #1;
        check_reset_vals("rst_async");
        repeat (hold) @(negedge CLK);
        check_reset_vals("rst_hold");
        RST        = 1'b1;
        n          = 0;
        run_frames = 0;
        snap[0]    = '0;
        snap[1]    = '0;
    endtask

    // Advance until the DUT's current state sits in digit slot idx at prescaler value p.
    task automatic advance_to(input int idx, input int p);
        int guard = 0;
        while (!(((n / D) % 7 == idx) && (n % D == p)) && guard < 2 * FR) begin
            tick();
            guard++;
        end
        compared++;
        assert (guard < 2 * FR) else begin
            mismatched++;
            $error("FAIL advance_to: observed timeout %0d expected < %0d", guard, 2 * FR);
        end
    endtask

    initial begin
        RST = 1'b1;
        STOPWATCH_RUN = 1'b1;
        {HOUR, MINHIGH, MINLOW, SECHIGH, SECLOW, MSEC1ST, MSEC2ND} = '0;
        snap[0] = '0;
        snap[1] = '0;
        @(negedge CLK);

        $display("step 1: power-up reset, two frames of zeros");
        do_reset(4);
        run(2 * FR);

        $display("step 2: digits 1:23:45.67");
        HOUR = 4'd1; MINHIGH = 3'd2; MINLOW = 4'd3; SECHIGH = 3'd4;
        SECLOW = 4'd5; MSEC1ST = 4'd6; MSEC2ND = 4'd7;
        run(2 * FR + 5);

        $display("step 3: SECLOW 5->6 mid-frame");
        advance_to(1, 2);
        SECLOW = 4'd6;
        run(2 * FR);

        $display("step 4: MSEC2ND=B shows dash");
        MSEC2ND = 4'hB;
        run(2 * FR);

        $display("step 5: reset pulse in slot 4");
        advance_to(4, 1);
        do_reset(1);
        run(2 * FR);

        $display("step 6: stopwatch stopped then running");
        STOPWATCH_RUN = 1'b0;
        run(6 * FR);
        STOPWATCH_RUN = 1'b1;
        run(2 * FR);

        $display("step 7: randomized inputs, run flag and resets");
        for (int t = 0; t < 40; t++) begin
            HOUR    = 4'($urandom_range(0, 15));
            MINHIGH = 3'($urandom_range(0, 7));
            MINLOW  = 4'($urandom_range(0, 15));
            SECHIGH = 3'($urandom_range(0, 7));
            SECLOW  = 4'($urandom_range(0, 15));
            MSEC1ST = 4'($urandom_range(0, 15));
            MSEC2ND = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                STOPWATCH_RUN = ~STOPWATCH_RUN;
            if ($urandom_range(0, 9) == 0)
                do_reset($urandom_range(1, 3));
            run($urandom_range(1, 60));
        end
        run(2 * FR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
